vga_timing_ctrl: RTL and testbench
==================================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameter H_SYNC, 10'd96: horizontal sync width, vga_clk cycles.
REQ-002 Parameter H_BACK, 10'd48: horizontal back porch, cycles.
REQ-003 Parameter H_VALID, 10'd640: active pixels per line.
REQ-004 Parameter H_FRONT, 10'd16: horizontal front porch; H_TOTAL = sum of the four horizontal parameters = 800.
REQ-005 Parameter V_SYNC, 10'd2: vertical sync width, lines.
REQ-006 Parameter V_BACK, 10'd33: vertical back porch, lines.
REQ-007 Parameter V_VALID, 10'd480: active lines per frame.
REQ-008 Parameter V_FRONT, 10'd10: vertical front porch; V_TOTAL = sum of the four vertical parameters = 525.
REQ-009 vga_clk  input  1  pixel clock, 25 MHz; all state on its rising edge.
REQ-010 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-011 pix_data  input  16  RGB565 colour from the pixel generator; registered there, so it lags its pix_x/pix_y by exactly 1 cycle.
REQ-012 pix_x  output  10  requested X coordinate, 0..H_VALID-1; 10'h3FF when no request.
REQ-013 pix_y  output  10  requested Y coordinate, 0..V_VALID-1; 10'h3FF when no request.
REQ-014 hsync  output  1  horizontal sync, active-low.
REQ-015 vsync  output  1  vertical sync, active-low.
REQ-016 rgb  output  16  colour to DAC; 16'h0000 outside the active window.
REQ-017 rgb_valid  output  1  high while the active window is being displayed.
REQ-018 frame_start  output  1  one-cycle pulse at the first cycle of each frame.
REQ-019 frame_cnt  output  8  count of completed frames, modulo 256.

Function
REQ-020 cnt_h: 10-bit register; counts 0..H_TOTAL-1; wraps to 0 after H_TOTAL-1.
REQ-021 cnt_v: 10-bit register; increments only when cnt_h == H_TOTAL-1; counts 0..V_TOTAL-1; wraps to 0 after V_TOTAL-1.
REQ-022 Simultaneous wrap (cnt_h == H_TOTAL-1 and cnt_v == V_TOTAL-1): both counters go to 0 on the same edge, and frame_cnt increments on that edge (255 wraps to 0).
REQ-023 hsync = 0 when cnt_h <= H_SYNC-1 (0..95); else 1. Combinational decode of the cnt_h register.
REQ-024 vsync = 0 when cnt_v <= V_SYNC-1 (0..1); else 1. Full lines; combinational decode.
REQ-025 Active window: cnt_h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VALID-1] = [144,783] AND cnt_v in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VALID-1] = [35,514]; rgb_valid = 1 exactly there.
REQ-026 Request window: same cnt_v range, cnt_h in [143,782] (one cycle ahead of the active window), compensating the 1-cycle pix_data latency.
REQ-027 Inside the request window: pix_x = cnt_h - (H_SYNC+H_BACK-1) and pix_y = cnt_v - (V_SYNC+V_BACK). Outside it, both are 10'h3FF.
REQ-028 rgb = pix_data while rgb_valid = 1, else 16'h0000; combinational mux. The pixel requested at pix_x = N is displayed at cnt_h = 144+N.
REQ-029 frame_start = 1 exactly when cnt_h == 0 and cnt_v == 0; one cycle per frame.
REQ-030 Frame period: exactly H_TOTAL*V_TOTAL = 420000 cycles; line period exactly 800 cycles.
REQ-031 No pix_x/pix_y outside 0..639 / 0..479 other than 10'h3FF.
REQ-032 pix_data is ignored when rgb_valid = 0.

Reset
REQ-033 While sys_rst_n = 0: cnt_h = 0, cnt_v = 0, frame_cnt = 0.
REQ-034 Resulting output values during reset: hsync = 0, vsync = 0, rgb_valid = 0, rgb = 0, pix_x = pix_y = 10'h3FF, frame_start = 1.
REQ-035 Reset asserted mid-line or mid-frame clears all state immediately, without waiting for a clock edge.
REQ-036 After deassertion, the first rising edge advances cnt_h to 1. No partial frame is counted.

Verification
REQ-037 Release reset, run 1 line -> hsync low for cycles 0..95 then high; line length 800; rgb_valid high for cnt_h 144..783 on line 35 only.
REQ-038 Run 2 frames -> vsync low for exactly 1600 cycles per frame; frame_start pulses 420000 cycles apart; frame_cnt 0->1->2.
REQ-039 Registered pix_data model returning {pix_x[5:0],pix_y[9:0]} -> at cnt_h=144+N, cnt_v=35+M, rgb == {N[5:0],M[9:0]} for N=0, 1, 639 and M=0, 479.
REQ-040 Check cnt_v=34 and 515, and cnt_h=142 and 783 -> pix_x/pix_y = 10'h3FF, except at cnt_h=782 on active lines, where pix_x=639.
REQ-041 Assert sys_rst_n=0 at cnt_h=400, cnt_v=200 for 3 cycles -> counters 0 immediately, hsync=0, rgb=0; a full first frame follows release.
REQ-042 Run 256 frames (or force frame_cnt=255) -> frame_cnt wraps 255->0 on the same edge both counters wrap.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: free-running horizontal/vertical counters, active-low
// syncs, a pixel request window one cycle ahead of the display window (to absorb
// the registered pixel generator), the RGB output gate, and a frame counter.
module vga_timing_ctrl #(
   parameter logic [9:0] H_SYNC  = 10'd96,
   parameter logic [9:0] H_BACK  = 10'd48,
   parameter logic [9:0] H_VALID = 10'd640,
   parameter logic [9:0] H_FRONT = 10'd16,
   parameter logic [9:0] V_SYNC  = 10'd2,
   parameter logic [9:0] V_BACK  = 10'd33,
   parameter logic [9:0] V_VALID = 10'd480,
   parameter logic [9:0] V_FRONT = 10'd10
) (
   input  logic        vga_clk,
   input  logic        sys_rst_n,
   input  logic [15:0] pix_data,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        hsync,
   output logic        vsync,
   output logic [15:0] rgb,
   output logic        rgb_valid,
   output logic        frame_start,
   output logic [7:0]  frame_cnt
);

   localparam logic [9:0] H_TOTAL     = H_SYNC + H_BACK + H_VALID + H_FRONT;
   localparam logic [9:0] V_TOTAL     = V_SYNC + V_BACK + V_VALID + V_FRONT;
   localparam logic [9:0] H_ACT_START = H_SYNC + H_BACK;
   localparam logic [9:0] H_ACT_END   = H_ACT_START + H_VALID - 10'd1;
   // The request window leads the display window by one cycle.
   localparam logic [9:0] H_REQ_START = H_ACT_START - 10'd1;
   localparam logic [9:0] H_REQ_END   = H_ACT_END - 10'd1;
   localparam logic [9:0] V_ACT_START = V_SYNC + V_BACK;
   localparam logic [9:0] V_ACT_END   = V_ACT_START + V_VALID - 10'd1;
   localparam logic [9:0] NO_REQ      = 10'h3FF;

   logic [9:0] cnt_h;
   logic [9:0] cnt_v;
   logic       h_end;
   logic       v_end;
   logic       v_active;
   logic       pix_req;

   assign h_end = (cnt_h == H_TOTAL - 10'd1);
   assign v_end = (cnt_v == V_TOTAL - 10'd1);

   // Horizontal counter: pixel position within the line, wraps every line.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      // NOTE: non-blocking assignments make all registers sample pre-edge values, so cnt_v/frame_cnt see the same h_end.
      if (!sys_rst_n)
         cnt_h <= '0;
      else if (h_end)
         cnt_h <= '0;
      else
         cnt_h <= cnt_h + 10'd1;
   end

   // Vertical counter: line index within the frame, advances on the last pixel of a line.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         cnt_v <= '0;
      else if (h_end) begin
         if (v_end)
            cnt_v <= '0;
         else
            cnt_v <= cnt_v + 10'd1;
      end
   end

   // Frame counter: counts completed frames on the edge where both counters wrap.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         frame_cnt <= '0;
      else if (h_end && v_end)
         frame_cnt <= frame_cnt + 8'd1;
   end

   // Decode syncs, windows, pixel coordinates and the RGB gate from the counters.
   always_comb begin
      // NOTE: every output gets a default first so no path through this block can infer a latch.
      hsync       = 1'b1;
      vsync       = 1'b1;
      v_active    = 1'b0;
      rgb_valid   = 1'b0;
      pix_req     = 1'b0;
      pix_x       = NO_REQ;
      pix_y       = NO_REQ;
      rgb         = 16'h0000;
      frame_start = 1'b0;

      if (cnt_h < H_SYNC)
         hsync = 1'b0;
      if (cnt_v < V_SYNC)
         vsync = 1'b0;

      v_active  = (cnt_v >= V_ACT_START) && (cnt_v <= V_ACT_END);
      rgb_valid = v_active && (cnt_h >= H_ACT_START) && (cnt_h <= H_ACT_END);
      pix_req   = v_active && (cnt_h >= H_REQ_START) && (cnt_h <= H_REQ_END);

      if (pix_req) begin
         pix_x = cnt_h - H_REQ_START;
         pix_y = cnt_v - V_ACT_START;
      end

      // pix_data is only passed through inside the display window.
      if (rgb_valid)
         rgb = pix_data;

      frame_start = (cnt_h == 10'd0) && (cnt_v == 10'd0);
   end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a full-size instance for reset, the first 36 lines
// and a mid-line reset; a shrunken instance for multi-frame, wrap and random resets.
// Expected values come from the elapsed cycle count since reset release.
module tb_vga_timing_ctrl;

   localparam int BHS = 96, BHB = 48, BHV = 640, BHF = 16;
   localparam int BVS = 2,  BVB = 33, BVV = 480, BVF = 10;
   localparam int SHS = 2,  SHB = 2,  SHV = 6,   SHF = 2;
   localparam int SVS = 2,  SVB = 2,  SVV = 3,   SVF = 1;
   localparam int BHT = BHS + BHB + BHV + BHF;   // 800
   localparam int SHT = SHS + SHB + SHV + SHF;   // 12
   localparam int SVT = SVS + SVB + SVV + SVF;   // 8
   localparam int SFT = SHT * SVT;               // 96

   logic vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   logic        rst_b_n, rst_s_n;
   logic [15:0] pd_b, pd_s, salt_b, salt_s;
   logic [9:0]  pix_x_b, pix_y_b, pix_x_s, pix_y_s;
   logic        hsync_b, vsync_b, rgb_valid_b, frame_start_b;
   logic        hsync_s, vsync_s, rgb_valid_s, frame_start_s;
   logic [15:0] rgb_b, rgb_s;
   logic [7:0]  frame_cnt_b, frame_cnt_s;
   logic [47:0] act_b, act_s, exp;

   int    total = 0;
   int    bad   = 0;
   longint t;

   assign act_b = {hsync_b, vsync_b, rgb_valid_b, frame_start_b, pix_x_b, pix_y_b, rgb_b, frame_cnt_b};
   assign act_s = {hsync_s, vsync_s, rgb_valid_s, frame_start_s, pix_x_s, pix_y_s, rgb_s, frame_cnt_s};

   vga_timing_ctrl u_big (
      .vga_clk(vga_clk), .sys_rst_n(rst_b_n), .pix_data(pd_b),
      .pix_x(pix_x_b), .pix_y(pix_y_b), .hsync(hsync_b), .vsync(vsync_b),
      .rgb(rgb_b), .rgb_valid(rgb_valid_b), .frame_start(frame_start_b),
      .frame_cnt(frame_cnt_b)
   );

   vga_timing_ctrl #(
      .H_SYNC(10'd2), .H_BACK(10'd2), .H_VALID(10'd6), .H_FRONT(10'd2),
      .V_SYNC(10'd2), .V_BACK(10'd2), .V_VALID(10'd3), .V_FRONT(10'd1)
   ) u_small (
      .vga_clk(vga_clk), .sys_rst_n(rst_s_n), .pix_data(pd_s),
      .pix_x(pix_x_s), .pix_y(pix_y_s), .hsync(hsync_s), .vsync(vsync_s),
      .rgb(rgb_s), .rgb_valid(rgb_valid_s), .frame_start(frame_start_s),
      .frame_cnt(frame_cnt_s)
   );

   // Pixel source pattern: {x[5:0], y} optionally scrambled by a salt.
   function automatic logic [15:0] gen(input logic [9:0] x, input logic [9:0] y,
                                        input logic [15:0] salt);
      return {x[5:0], y} ^ salt;
   endfunction

   // Registered pixel generators; garbage when nothing is requested.
   always @(posedge vga_clk) begin
      pd_b <= (pix_x_b == 10'h3FF) ? 16'($urandom) : gen(pix_x_b, pix_y_b, salt_b);
      pd_s <= (pix_x_s == 10'h3FF) ? 16'($urandom) : gen(pix_x_s, pix_y_s, salt_s);
   end

   // Reference: position derived from elapsed cycles t since reset release.
   function automatic logic [47:0] model(input longint t, input int hs, input int hb,
                                         input int hv, input int hf, input int vs,
                                         input int vb, input int vv, input int vf,
                                         input logic [15:0] salt);
      longint ht, vt, h, v, f;
      logic vact, act, req, fs;
      logic [9:0] px, py;
      logic [15:0] c;
      ht   = hs + hb + hv + hf;
      vt   = vs + vb + vv + vf;
      h    = t % ht;
      v    = (t / ht) % vt;
      f    = (t / (ht * vt)) % 256;
      vact = (v >= vs + vb) && (v < vs + vb + vv);
      act  = vact && (h >= hs + hb) && (h < hs + hb + hv);
      req  = vact && (h >= hs + hb - 1) && (h < hs + hb + hv - 1);
      px   = req ? 10'(h - (hs + hb - 1)) : 10'h3FF;
      py   = req ? 10'(v - (vs + vb)) : 10'h3FF;
      c    = act ? gen(10'(h - hs - hb), 10'(v - vs - vb), salt) : 16'h0000;
      fs   = (h == 0) && (v == 0);
      return {(h >= hs), (v >= vs), act, fs, px, py, c, 8'(f)};
   endfunction

   function automatic logic [47:0] model_b(input longint t, input logic [15:0] salt);
      return model(t, BHS, BHB, BHV, BHF, BVS, BVB, BVV, BVF, salt);
   endfunction

   function automatic logic [47:0] model_s(input longint t, input logic [15:0] salt);
      return model(t, SHS, SHB, SHV, SHF, SVS, SVB, SVV, SVF, salt);
   endfunction

   task automatic test_reset();
      rst_b_n = 1'b0;
      rst_s_n = 1'b0;
      salt_b  = 16'h0000;
      salt_s  = 16'h0000;
      for (int i = 0; i < 3; i++) begin
         @(negedge vga_clk);
         exp = model_b(0, salt_b);
         total++;
         if (act_b !== exp) begin
            bad++;
            $display("FAIL reset_big got=%h exp=%h", act_b, exp);
         end
         exp = model_s(0, salt_s);
         total++;
         if (act_s !== exp) begin
            bad++;
            $display("FAIL reset_small got=%h exp=%h", act_s, exp);
         end
      end
   endtask

   // First 36 full-size lines, every cycle against the model plus spot values.
   task automatic test_line();
      int hs_low, line35_valid, fs_cnt;
      logic [9:0] px_exp;
      hs_low = 0; line35_valid = 0; fs_cnt = 0;
      @(negedge vga_clk);
      rst_b_n = 1'b1;
      t = 0;
      for (int i = 0; i <= 36 * BHT + 8; i++) begin
         if (i > 0) begin
            @(negedge vga_clk);
            t++;
         end
         exp = model_b(t, salt_b);
         total++;
         if (act_b !== exp) begin
            bad++;
            if (bad <= 20) $display("FAIL line_big t=%0d got=%h exp=%h", t, act_b, exp);
         end
         if (t < BHT && !hsync_b) hs_low++;
         if (t / BHT == 35 && rgb_valid_b) line35_valid++;
         if (frame_start_b) fs_cnt++;
         if (t == 35 * BHT + 145) begin
            total++;
            if (rgb_b !== 16'h0400) begin
               bad++;
               $display("FAIL rgb_n1 got=%h exp=0400", rgb_b);
            end
         end
         if (t == 35 * BHT + 783) begin
            total++;
            if (rgb_b !== 16'hFC00) begin
               bad++;
               $display("FAIL rgb_n639 got=%h exp=fc00", rgb_b);
            end
         end
         if (t == 35 * BHT + 782 || t == 35 * BHT + 783 || t == 35 * BHT + 142 ||
             t == 34 * BHT + 400) begin
            px_exp = (t == 35 * BHT + 782) ? 10'd639 : 10'h3FF;
            total++;
            if (pix_x_b !== px_exp) begin
               bad++;
               $display("FAIL pix_x_edge t=%0d got=%h exp=%h", t, pix_x_b, px_exp);
            end
         end
      end
      total++;
      if (hs_low !== 96) begin
         bad++;
         $display("FAIL hsync_width got=%0d exp=96", hs_low);
      end
      total++;
      if (line35_valid !== 640) begin
         bad++;
         $display("FAIL line35_valid got=%0d exp=640", line35_valid);
      end
      total++;
      if (fs_cnt !== 1) begin
         bad++;
         $display("FAIL frame_start_count got=%0d exp=1", fs_cnt);
      end
   endtask

   // Reset the full-size instance at cnt_h=400 and follow one line after release.
   task automatic test_mid_line_reset();
      while (t % BHT != 400) begin
         @(negedge vga_clk);
         t++;
      end
      rst_b_n = 1'b0;
      #1;
      exp = model_b(0, salt_b);
      total++;
      if (act_b !== exp) begin
         bad++;
         $display("FAIL midline_async got=%h exp=%h", act_b, exp);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge vga_clk);
         total++;
         if (act_b !== exp) begin
            bad++;
            $display("FAIL midline_hold got=%h exp=%h", act_b, exp);
         end
      end
      rst_b_n = 1'b1;
      t = 0;
      for (int i = 1; i <= BHT + 4; i++) begin
         @(negedge vga_clk);
         t++;
         exp = model_b(t, salt_b);
         total++;
         if (act_b !== exp) begin
            bad++;
            if (bad <= 20) $display("FAIL midline_after t=%0d got=%h exp=%h", t, act_b, exp);
         end
      end
      rst_b_n = 1'b0;
   endtask

   // 257 small frames: every cycle vs model, vsync width, frame_start spacing, wrap.
   task automatic test_frames();
      int vs_low;
      longint last_fs;
      salt_s = 16'($urandom);
      @(negedge vga_clk);
      rst_s_n = 1'b1;
      t = 0;
      vs_low = 0;
      last_fs = 0;
      for (int i = 0; i <= 257 * SFT + 5; i++) begin
         if (i > 0) begin
            @(negedge vga_clk);
            t++;
         end
         exp = model_s(t, salt_s);
         total++;
         if (act_s !== exp) begin
            bad++;
            if (bad <= 20) $display("FAIL frames t=%0d got=%h exp=%h", t, act_s, exp);
         end
         if (!vsync_s) vs_low++;
         if (t % SFT == SFT - 1 && t < 2 * SFT) begin
            total++;
            if (vs_low !== SVS * SHT) begin
               bad++;
               $display("FAIL vsync_width got=%0d exp=%0d", vs_low, SVS * SHT);
            end
            vs_low = 0;
         end
         if (frame_start_s && t > 0) begin
            total++;
            if (t - last_fs !== longint'(SFT)) begin
               bad++;
               $display("FAIL frame_period got=%0d exp=%0d", t - last_fs, SFT);
            end
            last_fs = t;
         end
         if (t == 256 * SFT - 1 || t == 256 * SFT) begin
            total++;
            if (frame_cnt_s !== ((t == 256 * SFT) ? 8'd0 : 8'd255)) begin
               bad++;
               $display("FAIL frame_wrap t=%0d got=%0d", t, frame_cnt_s);
            end
         end
      end
   endtask

   // Random-position resets of the small instance with random hold lengths.
   task automatic test_random_resets();
      int run, hold;
      for (int k = 0; k < 4; k++) begin
         run  = $urandom_range(1, 300);
         hold = $urandom_range(1, 4);
         for (int i = 0; i < run; i++) begin
            @(negedge vga_clk);
            t++;
            exp = model_s(t, salt_s);
            total++;
            if (act_s !== exp) begin
               bad++;
               if (bad <= 20) $display("FAIL rnd_run t=%0d got=%h exp=%h", t, act_s, exp);
            end
         end
         rst_s_n = 1'b0;
         #1;
         exp = model_s(0, salt_s);
         total++;
         if (act_s !== exp) begin
            bad++;
            $display("FAIL rnd_async got=%h exp=%h", act_s, exp);
         end
         salt_s = 16'($urandom);
         for (int i = 0; i < hold; i++) begin
            @(negedge vga_clk);
            total++;
            if (act_s !== exp) begin
               bad++;
               $display("FAIL rnd_hold got=%h exp=%h", act_s, exp);
            end
         end
         rst_s_n = 1'b1;
         t = 0;
      end
      for (int i = 0; i < 2 * SFT; i++) begin
         @(negedge vga_clk);
         t++;
         exp = model_s(t, salt_s);
         total++;
         if (act_s !== exp) begin
            bad++;
            if (bad <= 20) $display("FAIL rnd_tail t=%0d got=%h exp=%h", t, act_s, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_line();
      test_mid_line_reset();
      test_frames();
      test_random_resets();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
